// File: rtl/ex3_a.sv
// Sliding-window accumulator: y is the registered sum of the last WIN valid samples.
// Idle cycles (x_is_valid low) leave both the window and the sum untouched.
module ex3_a #(
  parameter int DATA_W = 4,
  parameter int WIN    = 4,
  parameter int OUT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] x,
  input  logic              x_is_valid,
  output logic [OUT_W-1:0]  y
);

  logic [DATA_W-1:0] win_q [WIN];
  logic [DATA_W-1:0] win_d [WIN];
  logic [OUT_W-1:0]  y_q;
  logic [OUT_W-1:0]  y_d;

  // x is only referenced on the valid branch so garbage on an idle cycle cannot leak into state
  always_comb begin
    win_d = win_q;
    y_d   = y_q;
    if (x_is_valid) begin
      win_d[0] = x;
      for (int i = 1; i < WIN; i++) begin
        win_d[i] = win_q[i-1];
      end
      y_d = y_q + OUT_W'(x) - OUT_W'(win_q[WIN-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < WIN; i++) begin
        win_q[i] <= '0;
      end
      y_q <= '0;
    end else begin
      win_q <= win_d;
      y_q   <= y_d;
    end
  end

  assign y = y_q;

endmodule

// File: tb/tb_ex3_a.sv
// Bench for ex3_a: queue-based window model checked every cycle, plus literal
// expectations for the hand-worked sequences.
module tb_ex3_a;

  localparam int DATA_W = 4;
  localparam int WIN    = 4;
  localparam int OUT_W  = 6;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] x;
  logic              x_is_valid;
  logic [OUT_W-1:0]  y;

  int n_checks;
  int n_fail;

  int hist[$];
  int model_sum;
  bit model_ready;

  ex3_a #(.DATA_W(DATA_W), .WIN(WIN), .OUT_W(OUT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .x          (x),
    .x_is_valid (x_is_valid),
    .y          (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: newest-first list of accepted samples, at most WIN long; missing entries count as 0.
  always @(posedge clk) begin
    if (!rst) begin
      hist.delete();
      model_ready = 1'b1;
    end else if (x_is_valid) begin
      hist.push_front(int'(x));
      if (hist.size() > WIN) void'(hist.pop_back());
    end
    model_sum = 0;
    foreach (hist[i]) model_sum += hist[i];
  end

  always @(negedge clk) begin
    if (model_ready) begin
      n_checks++;
      if (int'(y) != model_sum) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t y=%0d expected=%0d", $time, y, model_sum);
      end
    end
  end

  task automatic step(input logic r, input logic v, input logic [DATA_W-1:0] xv);
    @(negedge clk);
    rst        = r;
    x_is_valid = v;
    x          = xv;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int exp);
    n_checks++;
    if (int'(y) != exp) begin
      n_fail++;
      $display("FAIL %s y=%0d expected=%0d", name, y, exp);
    end
  endtask

  initial begin
    int fill_exp [4];
    int drain_exp [4];
    logic [DATA_W-1:0] fill_x [4];
    n_checks    = 0;
    n_fail      = 0;
    model_ready = 1'b0;
    rst         = 1'b0;
    x           = 4'b0100;
    x_is_valid  = 1'b1;

    // reset held with valid data presented
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 4'b0100);
      chk("reset_hold", 0);
    end

    // fill
    fill_x   = '{4'd4, 4'd8, 4'd1, 4'd2};
    fill_exp = '{4, 12, 13, 15};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, fill_x[i]);
      chk("fill", fill_exp[i]);
    end

    // slide
    step(1'b1, 1'b1, 4'd8);
    chk("slide_8", 19);
    step(1'b1, 1'b1, 4'd0);
    chk("slide_0", 11);

    // hold with x toggling / undefined
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, (i % 2 == 0) ? 4'hF : 4'bxxxx);
      chk("hold", 11);
    end
    step(1'b1, 1'b1, 4'd3);
    chk("after_hold", 13);

    // max, no wrap
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 4'd15);
    chk("max", 60);
    drain_exp = '{45, 30, 15, 0};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 4'd0);
      chk("drain", drain_exp[i]);
    end

    // mid-stream reset
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 4'd15);
    chk("max_again", 60);
    step(1'b0, 1'b1, 4'd7);
    chk("mid_reset", 0);
    step(1'b1, 1'b1, 4'd5);
    chk("post_reset", 5);
    step(1'b1, 1'b1, 4'd6);
    chk("post_reset2", 11);

    // random traffic, checked by the model each cycle
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 49) != 0) ? 1'b1 : 1'b0,
           1'(($urandom_range(0, 3) != 0)),
           4'($urandom_range(0, 15)));
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
